roberts_stream: RTL and testbench
=================================

# roberts_stream

Streaming, parametrised Roberts-cross edge detector for raster-scan pixel streams. It replaces the fixed 8x8 whole-frame array with a single 2x2 window engine fed by a line buffer. Frame geometry, pixel width and output mode are set by parameters, and valid/ready handshakes with back-pressure are provided on both sides. It sits between the pixel source (frame loader) and the result sink (output serializer / memory writer).

## Interface
- IMG_W, 8: pixels per line, ≥2
- IMG_H, 8: lines per frame, ≥2
- PIX_W, 8: bits per pixel, in and out
- BINARY, 0: 0 = saturated magnitude output; 1 = thresholded output, all-ones or 0
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel present on in_pix
- in_ready  out  1  block accepts pixel this cycle
- in_pix  in  PIX_W  unsigned pixel, raster order
- in_sof  in  1  qualifies pixel as frame start (row 0, col 0)
- threshold  in  PIX_W  compare level, used when BINARY=1
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- out_pix  out  PIX_W  edge result
- out_sof  out  1  result belongs to pixel (0,0)
- out_eof  out  1  result belongs to pixel (IMG_H-1, IMG_W-1)

## Operation
- Transfer occurs when valid and ready are both high on a rising edge.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted pixel.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the last pixel of the frame.
  - An accepted pixel with in_sof=1 is treated as position (0,0) regardless of counters; counters continue from there (resync).
- Line buffer: IMG_W x PIX_W. Read at col returns the previous row's pixel; the current pixel is written at col in the same transfer.
- Registers hold a = prev-row pixel at col-1, b = prev-row pixel at col, c = current-row pixel at col-1, d = current pixel.
- Arithmetic: gx = a − d, gy = b − c, computed signed at PIX_W+1 bits. mag = |gx| + |gy| at PIX_W+1 bits, saturated to 2^PIX_W−1.
- Border: when row==0 or col==0, result = 0 (window incomplete). Line-buffer contents are ignored for row 0.
- BINARY=1: out_pix = all-ones if mag > threshold (strictly greater), else 0. threshold is sampled in the transfer cycle.
- One result per accepted pixel; output frame has the same size and order as the input.

## Timing
- Latency: 1 cycle. Pixel accepted at edge N produces out_valid=1 after edge N, with out_sof/out_eof aligned to it.
- Single output register stage: in_ready = !out_valid | out_ready (combinational).
- Output register rules:
  - Holds out_pix/out_sof/out_eof stable while out_valid & !out_ready.
  - Simultaneous output transfer and input transfer: register reloads and out_valid stays 1.
  - Output transfer with no input: out_valid drops to 0.
- Reset values: out_valid=0, out_pix=0, out_sof=0, out_eof=0, row=col=0, window registers 0. in_ready=1 after reset.
- Line buffer is not cleared by reset; contents are masked by row==0 border rule.
- Reset mid-frame discards the in-flight result; the next accepted pixel is (0,0) even without in_sof.
- Stall on input (in_valid=0) leaves all state unchanged.

## Structure
- Package roberts_pkg holds:
  - localparam-style constants PIX_MAX
  - function sat_add(|gx|,|gy|) returning PIX_W bits
  - function abs_diff
  - counter width via $clog2
- Sub-module roberts_line_buf (parameters DEPTH=IMG_W, W=PIX_W): one-port read-before-write RAM with registered read enable tied to transfer. The top module holds counters, window registers, arithmetic and the output stage.

## Test plan
- IMG_W=IMG_H=4, PIX_W=8, BINARY=0; constant 50 frame, out_ready=1 → 16 results all 0; out_sof on first, out_eof on 16th; latency 1.
- Vertical step (cols 0–1 = 0, cols 2–3 = 100) → rows 1–3 col 2 = 200; all other results 0.
- Diagonal worst case, pixel (1,1)=200 with 0 elsewhere in a 2x2 → |gx|=200, |gy|=0 → 200. Vertical step of 200 at col 2 → mag 400 saturates to 255.
- BINARY=1, threshold=150, vertical step of 100 (mag 200) → 255 at step, 0 elsewhere. threshold=200 → all 0 (strict compare).
- Random out_ready toggling (50%) and random in_valid gaps → output sequence identical to the no-stall run; out_pix stable while stalled; no drops or duplicates.
- Reset asserted after pixel 6, then a fresh frame without in_sof → output matches a clean-frame run; in_sof asserted at mid-frame col 2 → counters resync, that result has out_sof=1 and value 0.

Source files
------------

// File: rtl/roberts_pkg.sv
// Shared constants and arithmetic helpers for the Roberts-cross edge engine.
package roberts_pkg;

  // Widest pixel the helpers below can handle; the top slices results down.
  localparam int MAX_W     = 16;
  localparam int PIX_W_DEF = 8;
  localparam int PIX_MAX   = (1 << PIX_W_DEF) - 1;

  typedef logic [MAX_W-1:0] wide_t;

  // Sideband that travels with each result.
  typedef struct packed {
    logic sof;
    logic eof;
  } pix_tag_t;

  // Unsigned |x - y|; always fits in MAX_W bits for MAX_W-bit operands.
  function automatic wide_t abs_diff(input wide_t x, input wide_t y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  // |gx| + |gy| clipped to the largest w-bit value.
  function automatic wide_t sat_add(input wide_t ax, input wide_t ay, input int w);
    logic [MAX_W:0] one;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    one = {{MAX_W{1'b0}}, 1'b1};
    sum = {1'b0, ax} + {1'b0, ay};
    lim = (one << w) - one;
    return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/roberts_line_buf.sv
// One-line pixel store. Combinational read of the previous row at addr_i,
// plus a copy of that read captured on each transfer (the window's "a" tap
// one pixel later). Memory itself is never cleared.
module roberts_line_buf #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [W-1:0]             wr_data_i,
  output logic [W-1:0]             rd_data_o,
  output logic [W-1:0]             rd_q_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  assign rd_data_o = mem_q[addr_i];
  assign rd_q_o    = rd_q;

  // Write the current pixel into its column on every transfer.
  always_ff @(posedge clk_i) begin
    if (en_i) mem_q[addr_i] <= wr_data_i;
  end

  // Hold the pre-write read value so it is available as the next column's left tap.
  always_ff @(posedge clk_i) begin
    if (reset_i)   rd_q <= '0;
    else if (en_i) rd_q <= mem_q[addr_i];
  end

endmodule

// File: rtl/roberts_stream.sv
// Streaming Roberts-cross edge detector: 2x2 window over a raster stream,
// one result per accepted pixel, single output register with back-pressure.
module roberts_stream
  import roberts_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 8,
  parameter int BINARY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eof
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic [PIX_W-1:0] c_q;
  logic [PIX_W-1:0] tap_a, tap_b;
  logic [PIX_W-1:0] mag, res;
  logic             thr_hit, border;
  logic             xfer_in;
  pix_tag_t         tag;

  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  pix_tag_t         out_tag_q, out_tag_d;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;

  // Previous-row taps: b at this column, a at the column before.
  roberts_line_buf #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_line_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .en_i      (xfer_in),
    .addr_i    (col_eff[$clog2(IMG_W)-1:0]),
    .wr_data_i (in_pix),
    .rd_data_o (tap_b),
    .rd_q_o    (tap_a)
  );

  // Position of the incoming pixel (sof forces 0,0) and the position after it.
  always_comb begin
    col_eff = in_sof ? '0 : col_q;
    row_eff = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (xfer_in) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  // Gradient magnitude for window a b / c d, masked on the top row and left column.
  always_comb begin
    mag     = PIX_W'(sat_add(abs_diff(MAX_W'(tap_a), MAX_W'(in_pix)),
                             abs_diff(MAX_W'(tap_b), MAX_W'(c_q)), PIX_W));
    thr_hit = mag > threshold;
    border  = (row_eff == '0) || (col_eff == '0);
    res     = '0;
    if (!border) begin
      if (BINARY != 0) res = thr_hit ? '1 : '0;
      else             res = mag;
    end
    tag.sof = (row_eff == '0) && (col_eff == '0);
    tag.eof = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  end

  // Output register next-state: reload on input transfer, drop valid once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_tag_d   = out_tag_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_pix_d   = res;
      out_tag_d   = tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Position counters, current-row left tap and output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      if (xfer_in) c_q <= in_pix;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_sof   = out_tag_q.sof;
  assign out_eof   = out_tag_q.eof;

endmodule

// File: tb/tb_roberts_stream.sv
// Bench for roberts_stream: a magnitude instance and a thresholded instance
// share one input stream; expected results come from a frame-array model.
module tb_roberts_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, in_sof, out_ready;
  logic [PW-1:0] in_pix, threshold;
  logic          in_ready0, out_valid0, out_sof0, out_eof0;
  logic          in_ready1, out_valid1, out_sof1, out_eof1;
  logic [PW-1:0] out_pix0, out_pix1;

  roberts_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BINARY(0)) dut_mag (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pix(in_pix), .in_sof(in_sof), .threshold(threshold),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pix(out_pix0),
    .out_sof(out_sof0), .out_eof(out_eof0));

  roberts_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .BINARY(1)) dut_bin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pix(in_pix), .in_sof(in_sof), .threshold(threshold),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pix(out_pix1),
    .out_sof(out_sof1), .out_eof(out_eof1));

  typedef struct {
    int mag;
    int bin;
    bit sof;
    bit eof;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   img[H][W];
  int   fr[H][W];
  int   pr = 0, pc = 0;
  bit   mdl_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Model of one accepted pixel: place it in the frame, predict its result.
  task automatic push_expected(input int pix, input bit sof);
    exp_t e;
    int   m;
    if (sof) begin
      pr = 0;
      pc = 0;
    end
    img[pr][pc] = pix;
    if (pr == 0 || pc == 0) m = 0;
    else begin
      m = iabs(img[pr-1][pc-1] - pix) + iabs(img[pr-1][pc] - img[pr][pc-1]);
      if (m > 255) m = 255;
    end
    e.mag = m;
    e.bin = (m > int'(threshold)) ? 255 : 0;
    e.sof = (pr == 0 && pc == 0);
    e.eof = (pr == H-1 && pc == W-1);
    q.push_back(e);
    pc++;
    if (pc == W) begin
      pc = 0;
      pr = (pr == H-1) ? 0 : pr + 1;
    end
  endtask

  // One clock: drive at the falling edge, check just after, step to next falling edge.
  task automatic cycle(input bit v, input logic [PW-1:0] pix, input bit sof,
                       input bit rdy, output bit took);
    bit pop;
    in_valid  = v;
    in_pix    = pix;
    in_sof    = sof;
    out_ready = rdy;
    #1;
    chk("out_valid_mag", out_valid0, mdl_valid);
    chk("out_valid_bin", out_valid1, mdl_valid);
    chk("in_ready_mag", in_ready0, (!mdl_valid || rdy));
    chk("in_ready_bin", in_ready1, (!mdl_valid || rdy));
    if (mdl_valid && q.size() > 0) begin
      chk("out_pix_mag", out_pix0, q[0].mag);
      chk("out_pix_bin", out_pix1, q[0].bin);
      chk("out_sof_mag", out_sof0, q[0].sof);
      chk("out_eof_mag", out_eof0, q[0].eof);
      chk("out_sof_bin", out_sof1, q[0].sof);
      chk("out_eof_bin", out_eof1, q[0].eof);
    end
    took = v && (!mdl_valid || rdy);
    pop  = mdl_valid && rdy;
    if (pop) void'(q.pop_front());
    if (took) push_expected(int'(pix), sof);
    if (took)     mdl_valid = 1'b1;
    else if (pop) mdl_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pixel(input int pix, input bit sof, input int gap_pct, input int rdy_pct);
    bit took;
    int tries;
    took  = 1'b0;
    tries = 0;
    while (!took && tries < 200) begin
      cycle(($urandom_range(99) >= gap_pct), PW'(pix), sof,
            ($urandom_range(99) < rdy_pct), took);
      tries++;
    end
    if (!took) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=%0d", tries, 200);
    end
  endtask

  task automatic send_frame(input bit sof_first, input int gap_pct, input int rdy_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(fr[r][c], (sof_first && r == 0 && c == 0), gap_pct, rdy_pct);
  endtask

  task automatic drain();
    bit took;
    for (int i = 0; i < 20; i++) cycle(1'b0, PW'($urandom), 1'b0, 1'b1, took);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    mdl_valid = 1'b0;
    pr = 0;
    pc = 0;
    #1;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_pix", out_pix0, 0);
    chk("rst_out_sof", out_sof0, 0);
    chk("rst_out_eof", out_eof0, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid_bin", out_valid1, 0);
    @(negedge clk);
  endtask

  task automatic fill_step(input int lo, input int hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = (c < 2) ? lo : hi;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pix    = '0;
    out_ready = 1'b0;
    threshold = 8'd150;
    repeat (2) @(negedge clk);
    do_reset();

    // Flat frame: every result zero, sof on first, eof on last.
    fill_step(50, 50);
    send_frame(1'b1, 0, 100);
    drain();

    // Vertical step of 100: magnitude 200 at column 2 below row 0.
    fill_step(0, 100);
    send_frame(1'b1, 0, 100);
    drain();

    // Single bright pixel at (1,1).
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = (r == 1 && c == 1) ? 200 : 0;
    send_frame(1'b1, 0, 100);
    drain();

    // Step of 200: magnitude 400 saturates.
    fill_step(0, 200);
    send_frame(1'b1, 0, 100);
    drain();

    // Strict threshold: magnitude 200 does not exceed 200.
    threshold = 8'd200;
    fill_step(0, 100);
    send_frame(1'b1, 0, 100);
    drain();
    threshold = 8'd150;

    // Random frames with input gaps and output back-pressure.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          fr[r][c] = int'($urandom_range(255));
      send_frame(1'b1, 30, 50);
    end
    drain();

    // Reset after six pixels, then a frame with no sof marker.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = int'($urandom_range(255));
    for (int i = 0; i < 6; i++) send_pixel(fr[i / W][i % W], (i == 0), 0, 100);
    do_reset();
    send_frame(1'b0, 20, 70);
    drain();

    // Mid-frame resync: sof arrives at column 2 of row 1.
    for (int i = 0; i < 6; i++) send_pixel(int'($urandom_range(255)), (i == 0), 0, 100);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = int'($urandom_range(255));
    send_frame(1'b1, 10, 60);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
